// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin memory bus arbiter with burst cap.
// Define ARB_LOCK_EN to add m0_lock/m1_lock, which suspend the burst cap for the owner.
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
`ifdef ARB_LOCK_EN
  input  logic          m0_lock,
  input  logic          m1_lock,
`endif
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_we,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_wait,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_we,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_wait,
  output logic [AW-1:0] m_addr,
  output logic          m_cs,
  output logic          m_we,
  output logic [DW-1:0] m_otdata,
  input  logic [DW-1:0] m_idata,
  input  logic          m_wait,
  output logic [1:0]    owner
);
  typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;
  localparam logic [4:0] CAP = 5'(MAX_BURST);
  state_t state_q, state_d;
  logic last_q, last_d;
  logic [3:0] bcnt_q, bcnt_d;
  logic own, sel, sel_req, oth_req, sel_lock, at_cap;
  logic [4:0] bnext;
  assign own = state_q != IDLE;
  assign sel = state_q == OWN1;
  assign sel_req = sel ? m1_req : m0_req;
  assign oth_req = sel ? m0_req : m1_req;
`ifdef ARB_LOCK_EN
  assign sel_lock = sel ? m1_lock : m0_lock;
`else
  assign sel_lock = 1'b0;
`endif
  assign bnext = {1'b0, bcnt_q} + 5'd1;
  assign at_cap = bnext >= CAP;
  assign m_addr = own ? (sel ? m1_addr : m0_addr) : '0;
  assign m_otdata = own ? (sel ? m1_wdata : m0_wdata) : '0;
  assign m_cs = own & sel_req;
  assign m_we = m_cs & (sel ? m1_we : m0_we);
  assign m0_wait = m0_req & ~(state_q == OWN0 & ~m_wait);
  assign m1_wait = m1_req & ~(state_q == OWN1 & ~m_wait);
  // read data is a broadcast, forced to zero while reset is held
  assign m0_rdata = rst ? m_idata : '0;
  assign m1_rdata = rst ? m_idata : '0;
  assign owner = state_q;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    bcnt_d = bcnt_q;
    if (!own) begin
      if (m0_req & (~m1_req | last_q)) state_d = OWN0;
      else if (m1_req) state_d = OWN1;
    end else if (!sel_req) begin
      state_d = oth_req ? (sel ? OWN0 : OWN1) : IDLE;
      bcnt_d = '0;
    end else if (!m_wait) begin
      last_d = sel;
      if (oth_req & ~sel_lock & at_cap) begin
        state_d = sel ? OWN0 : OWN1;
        bcnt_d = '0;
      end else begin
        bcnt_d = at_cap ? CAP[3:0] : bnext[3:0];
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      bcnt_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      bcnt_q <= bcnt_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic checked against a rule-level model.
module tb_mem_arbiter;
  localparam int MAXB = 4;
  logic clk = 0, rst = 0;
  logic req [2], we [2];
  logic [15:0] addr [2];
  logic [7:0] wd [2];
`ifdef ARB_LOCK_EN
  logic lock [2];
  localparam int T6_EXP = 6;
`else
  localparam int T6_EXP = 4;
`endif
  logic [7:0] r0, r1, idata, od;
  logic w0, w1, cs, mwe, mwait;
  logic [15:0] ma;
  logic [1:0] owner;
  int tests = 0, fails = 0;
  int cur, last, bcnt;
  bit exp_done [2];
  bit obs_done0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
`ifdef ARB_LOCK_EN
    .m0_lock(lock[0]), .m1_lock(lock[1]),
`endif
    .m0_req(req[0]), .m0_addr(addr[0]), .m0_we(we[0]), .m0_wdata(wd[0]),
    .m0_rdata(r0), .m0_wait(w0),
    .m1_req(req[1]), .m1_addr(addr[1]), .m1_we(we[1]), .m1_wdata(wd[1]),
    .m1_rdata(r1), .m1_wait(w1),
    .m_addr(ma), .m_cs(cs), .m_we(mwe), .m_otdata(od), .m_idata(idata),
    .m_wait(mwait), .owner(owner)
  );

  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // serving rules applied at each rising edge
  task automatic model_edge();
    bit lk = 0;
    if (cur < 0) begin
      if (req[0] && req[1]) cur = 1 - last;
      else if (req[0]) cur = 0;
      else if (req[1]) cur = 1;
    end else if (!req[cur]) begin
      bcnt = 0;
      cur = req[1-cur] ? 1 - cur : -1;
    end else if (!mwait) begin
`ifdef ARB_LOCK_EN
      lk = lock[cur];
`endif
      last = cur;
      bcnt = bcnt + 1;
      if (req[1-cur] && bcnt >= MAXB && !lk) begin
        cur = 1 - cur;
        bcnt = 0;
      end else if (bcnt > MAXB) bcnt = MAXB;
    end
  endtask

  task automatic step();
    bit ew;
    #1;
    if (!rst) begin cur = -1; last = 1; bcnt = 0; end
    check("m_cs", cs, cur >= 0 && req[cur]);
    check("m_we", mwe, cur >= 0 && req[cur] && we[cur]);
    check("m_addr", ma, cur >= 0 ? addr[cur] : 16'h0);
    check("m_otdata", od, cur >= 0 ? wd[cur] : 8'h0);
    check("owner", owner, cur < 0 ? 0 : (cur == 0 ? 1 : 2));
    check("m0_rdata", r0, rst ? idata : 8'h0);
    check("m1_rdata", r1, rst ? idata : 8'h0);
    for (int k = 0; k < 2; k++) begin
      ew = req[k] && !(cur == k && !mwait);
      exp_done[k] = req[k] && !ew;
      check(k == 0 ? "m0_wait" : "m1_wait", k == 0 ? w0 : w1, ew);
    end
    obs_done0 = req[0] && !w0;
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
  endtask

  task automatic set_m(int k, logic r, logic w, logic [15:0] a, logic [7:0] d);
    req[k] = r; we[k] = w; addr[k] = a; wd[k] = d;
  endtask

  task automatic pulse_reset();
    rst = 0;
    step();
    rst = 1;
  endtask

  initial begin
    int n;
    cur = -1; last = 1; bcnt = 0;
    set_m(0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0);
`ifdef ARB_LOCK_EN
    lock[0] = 0; lock[1] = 0;
`endif
    idata = 8'h00; mwait = 0;
    @(negedge clk);
    step();
    step();
    rst = 1;
    // single read
    set_m(0, 1, 0, 16'h0001, 8'h00);
    idata = 8'h55;
    step();
    check("t2_wait_low", w0, 0);
    check("t2_rdata", r0, 8'h55);
    check("t2_cs", cs, 1);
    check("t2_we", mwe, 0);
    step();
    set_m(0, 0, 0, 0, 0);
    step();
    // reset in the middle of a stalled write
    set_m(0, 1, 1, 16'h0003, 8'h77);
    mwait = 1;
    step();
    step();
    check("t1_pre_addr", ma, 16'h0003);
    rst = 0;
    #1;
    check("t1_rst_cs", cs, 0);
    check("t1_rst_we", mwe, 0);
    check("t1_rst_addr", ma, 0);
    check("t1_rst_od", od, 0);
    check("t1_rst_owner", owner, 0);
    step();
    rst = 1;
    mwait = 0;
    // both request after reset: m0 first, four accesses, then m1 with no idle gap
    set_m(0, 1, 0, 16'h0010, 8'h00);
    set_m(1, 1, 0, 16'h0020, 8'h00);
    step();
    check("t1_grant_m0", owner, 2'b01);
    for (int i = 0; i < 4; i++) begin
      check("t3_owner_m0", owner, 2'b01);
      step();
    end
    check("t3_handoff", owner, 2'b10);
    // stalled write by m1 with m0 waiting
    set_m(1, 1, 1, 16'h000F, 8'hAA);
    mwait = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_m1_wait", w1, 1);
      check("t4_addr", ma, 16'h000F);
      check("t4_data", od, 8'hAA);
      check("t4_owner", owner, 2'b10);
    end
    mwait = 0;
    step();
    set_m(1, 1, 0, 16'h0021, 8'h00);
    step();
    check("t4_keep_m1", owner, 2'b10);
    set_m(1, 0, 0, 0, 0);
    set_m(0, 0, 0, 0, 0);
    // owner release with simultaneous request from the other master
    pulse_reset();
    set_m(0, 1, 0, 16'h0030, 8'h00);
    step();
    step();
    set_m(0, 0, 0, 0, 0);
    set_m(1, 1, 0, 16'h0040, 8'h00);
    step();
    check("t5_switch", owner, 2'b10);
    set_m(1, 0, 0, 0, 0);
    step();
    // burst length seen by m0 while m1 waits
    pulse_reset();
    set_m(0, 1, 0, 16'h0050, 8'h00);
    set_m(1, 1, 0, 16'h0060, 8'h00);
`ifdef ARB_LOCK_EN
    lock[0] = 1;
`endif
    n = 0;
    for (int i = 0; i < 20 && owner != 2'b10; i++) begin
      if (n == 6) req[0] = 0;
      step();
      if (obs_done0) n++;
    end
    check("t6_reached_m1", owner, 2'b10);
    check("t6_burst", n, T6_EXP);
`ifdef ARB_LOCK_EN
    lock[0] = 0;
`endif
    set_m(0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0);
    step();
    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 2; k++)
        if (!req[k] || exp_done[k]) begin
          set_m(k, $urandom_range(0, 3) != 0, 1'($urandom), 16'($urandom), 8'($urandom));
`ifdef ARB_LOCK_EN
          lock[k] = $urandom_range(0, 7) == 0;
`endif
        end
      mwait = $urandom_range(0, 3) == 0;
      idata = 8'($urandom);
      rst = $urandom_range(0, 199) != 0;
      step();
    end
    rst = 1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
